// File: rtl/id_decode_queue_pkg.sv
// Shared types and constants for the id_decode_queue decode stage.
// Optional RV32M decode is enabled by defining ID_RV32M_EN (see id_decode_queue_core).
package id_decode_queue_pkg;

    localparam int INST_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic              r1_en;
        logic              r2_en;
        logic [INST_W-1:0] imm;
        logic              illegal;
    } dec_t;

endpackage

// File: rtl/id_decode_queue_if.sv
// Handshake bundle between IF, the decode queue and dispatch.
// slave = decode stage side, master = the IF/dispatch environment.
interface id_decode_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int OPT_W  = 6
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [31:0]       in_inst;
    logic              in_jump;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [OPT_W-1:0]  out_op;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic              out_r1_en;
    logic              out_r2_en;
    logic [31:0]       out_imm;
    logic              out_jump;
    logic              out_illegal;
    logic [CW-1:0]     count;

    modport slave (
        input  rdy, flush, in_valid, in_pc, in_inst, in_jump, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_r1_en, out_r2_en, out_imm, out_jump, out_illegal, count
    );

    modport master (
        output rdy, flush, in_valid, in_pc, in_inst, in_jump, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_r1_en, out_r2_en, out_imm, out_jump, out_illegal, count
    );

endinterface

// File: rtl/id_decode_queue_core.sv
// Combinational RV32I decoder: raw instruction -> op, register fields, immediate.
// Define ID_RV32M_EN to decode the M-extension (funct7 = 0000001 on OP);
// otherwise those encodings are reported illegal.
module id_decode_queue_core
    import id_decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        bad;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{21{inst[31]}}, inst[30:20]};
    assign imm_s  = {{21{inst[31]}}, inst[30:25], inst[11:7]};
    assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    // Decode by opcode/funct; any unrecognised encoding collapses to an illegal NOP.
    always_comb begin
        dec    = '0;
        dec.op = OP_NOP;
        bad    = 1'b0;
        case (opcode)
            OPC_LUI:   begin dec.op = OP_LUI;   dec.rd = rd; dec.imm = imm_u; end
            OPC_AUIPC: begin dec.op = OP_AUIPC; dec.rd = rd; dec.imm = imm_u; end
            OPC_JAL:   begin dec.op = OP_JAL;   dec.rd = rd; dec.imm = imm_j; end
            OPC_JALR: begin
                dec.op = OP_JALR; dec.rd = rd; dec.rs1 = rs1; dec.r1_en = 1'b1; dec.imm = imm_i;
                bad = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec.rs1 = rs1; dec.rs2 = rs2; dec.r1_en = 1'b1; dec.r2_en = 1'b1; dec.imm = imm_b;
                case (f3)
                    3'd0: dec.op = OP_BEQ;
                    3'd1: dec.op = OP_BNE;
                    3'd4: dec.op = OP_BLT;
                    3'd5: dec.op = OP_BGE;
                    3'd6: dec.op = OP_BLTU;
                    3'd7: dec.op = OP_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.rd = rd; dec.rs1 = rs1; dec.r1_en = 1'b1; dec.imm = imm_i;
                case (f3)
                    3'd0: dec.op = OP_LB;
                    3'd1: dec.op = OP_LH;
                    3'd2: dec.op = OP_LW;
                    3'd4: dec.op = OP_LBU;
                    3'd5: dec.op = OP_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.rs1 = rs1; dec.rs2 = rs2; dec.r1_en = 1'b1; dec.r2_en = 1'b1; dec.imm = imm_s;
                case (f3)
                    3'd0: dec.op = OP_SB;
                    3'd1: dec.op = OP_SH;
                    3'd2: dec.op = OP_SW;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.rd = rd; dec.rs1 = rs1; dec.r1_en = 1'b1; dec.imm = imm_i;
                case (f3)
                    3'd0: dec.op = OP_ADDI;
                    3'd2: dec.op = OP_SLTI;
                    3'd3: dec.op = OP_SLTIU;
                    3'd4: dec.op = OP_XORI;
                    3'd6: dec.op = OP_ORI;
                    3'd7: dec.op = OP_ANDI;
                    3'd1: begin dec.op = OP_SLLI; bad = (f7 != 7'b0000000); end
                    3'd5: begin
                        if (f7 == 7'b0000000)      dec.op = OP_SRLI;
                        else if (f7 == 7'b0100000) dec.op = OP_SRAI;
                        else                       bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec.rd = rd; dec.rs1 = rs1; dec.rs2 = rs2; dec.r1_en = 1'b1; dec.r2_en = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'd0: dec.op = OP_ADD;
                            3'd1: dec.op = OP_SLL;
                            3'd2: dec.op = OP_SLT;
                            3'd3: dec.op = OP_SLTU;
                            3'd4: dec.op = OP_XOR;
                            3'd5: dec.op = OP_SRL;
                            3'd6: dec.op = OP_OR;
                            default: dec.op = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'd0)      dec.op = OP_SUB;
                        else if (f3 == 3'd5) dec.op = OP_SRA;
                        else                 bad = 1'b1;
                    end
`ifdef ID_RV32M_EN
                    7'b0000001: begin
                        case (f3)
                            3'd0: dec.op = OP_MUL;
                            3'd1: dec.op = OP_MULH;
                            3'd2: dec.op = OP_MULHSU;
                            3'd3: dec.op = OP_MULHU;
                            3'd4: dec.op = OP_DIV;
                            3'd5: dec.op = OP_DIVU;
                            3'd6: dec.op = OP_REM;
                            default: dec.op = OP_REMU;
                        endcase
                    end
`else
`endif
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.op      = OP_NOP;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: DEPTH-entry FIFO of fetched (pc, inst, jump) feeding a registered decoder.
// Freeze on !rdy, discard everything on flush. ID_RV32M_EN selects M-extension decode.
module id_decode_queue
    import id_decode_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int OPT_W  = 6
) (
    input logic              clk,
    input logic              rst,
    id_decode_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [31:0]       mem_inst [DEPTH];
    logic              mem_jump [DEPTH];

    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;
    logic              in_ready, push, pop;
    dec_t              head_dec;

    logic              out_valid_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic [OPT_W-1:0]  out_op_q;
    logic [4:0]        out_rd_q, out_rs1_q, out_rs2_q;
    logic              out_r1_q, out_r2_q, out_jump_q, out_ill_q;
    logic [31:0]       out_imm_q;

    // The output register counts as an extra slot, so pop whenever it is free or being drained.
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = bus.in_valid && in_ready;
    assign pop      = (count_q != '0) && (!out_valid_q || bus.out_ready);

    id_decode_queue_core u_core (
        .inst (mem_inst[rd_ptr]),
        .dec  (head_dec)
    );

    // Queue storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && !bus.flush && push) begin
            mem_pc[wr_ptr]   <= bus.in_pc;
            mem_inst[wr_ptr] <= bus.in_inst;
            mem_jump[wr_ptr] <= bus.in_jump;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (pop && !push) count_q <= count_q - CW'(1);
            end
        end
    end

    // Output register: load decoded head on pop, otherwise retire on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_op_q    <= OPT_W'(OP_NOP);
            out_rd_q    <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_r1_q    <= 1'b0;
            out_r2_q    <= 1'b0;
            out_imm_q   <= '0;
            out_jump_q  <= 1'b0;
            out_ill_q   <= 1'b0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (pop) begin
                out_valid_q <= 1'b1;
                out_pc_q    <= mem_pc[rd_ptr];
                out_op_q    <= OPT_W'(head_dec.op);
                out_rd_q    <= head_dec.rd;
                out_rs1_q   <= head_dec.rs1;
                out_rs2_q   <= head_dec.rs2;
                out_r1_q    <= head_dec.r1_en;
                out_r2_q    <= head_dec.r2_en;
                out_imm_q   <= head_dec.imm;
                out_jump_q  <= mem_jump[rd_ptr];
                out_ill_q   <= head_dec.illegal;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.count       = count_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_rs1     = out_rs1_q;
    assign bus.out_rs2     = out_rs2_q;
    assign bus.out_r1_en   = out_r1_q;
    assign bus.out_r2_en   = out_r2_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_jump    = out_jump_q;
    assign bus.out_illegal = out_ill_q;

endmodule
